sensor_view_scheduler: RTL and testbench
========================================

# sensor_view_scheduler

Sequencing and display-arbitration controller between the HC-SR04 distance front end, the KY-040 encoder counter and the TM1638 seven-segment/LED drivers. It periodically triggers and supervises distance measurements with a timeout. It selects which sensor view is shown, either by key mode or by timed auto-rotation, and supports a freeze (hold) function. It produces the registered 32-bit number, dots and LED level bar consumed by `seven_segment_display` and the `led` outputs.

## Interface
- `CLK_HZ`, 27_000_000, clock frequency; derives a 1 ms tick.
- `MEAS_PERIOD_MS`, 60, trigger-to-trigger measurement period.
- `TIMEOUT_MS`, 40, max wait for `meas_done` after `meas_start`.
- `DWELL_MS`, 2000, per-view dwell time in auto-rotate mode.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `mode_key` in 2: synced/debounced view mode (00 distance, 01 encoder, 10 difference, 11 auto).
- `hold_key` in 1: synced/debounced level; a rising edge toggles freeze.
- `meas_start` out 1: single-cycle pulse that starts one distance measurement.
- `meas_done` in 1: single-cycle pulse; `dist_in` is valid in the same cycle.
- `dist_in` in 16: relative distance from the sensor front end.
- `enc_in` in 16: encoder value (free-running, sampled every cycle).
- `number` out 32: value to the seven-segment driver.
- `dots` out 8: status dots.
- `led_bar` out 8: thermometer level bar.
- `src_sel` out 2: currently displayed source index.

## Operation
- **Tick:** a prescaler counts 0..CLK_HZ/1000-1 and emits a 1-cycle `ms_tick` at wrap. All ms counters advance only on `ms_tick`.
- **Measurement FSM states:** IDLE, TRIG, WAIT, GAP.
  - IDLE -> TRIG unconditionally.
  - TRIG: `meas_start`=1 for exactly one cycle. Clear `period_cnt` and `wait_cnt`. Go to WAIT.
  - WAIT: on `meas_done`, `dist_q`<=`dist_in`, `tmo_flag`<=0, go to GAP. If `wait_cnt` reaches TIMEOUT_MS first, `dist_q`<=16'hFFFF, `tmo_flag`<=1, go to GAP.
  - GAP: when `period_cnt` reaches MEAS_PERIOD_MS (counted from TRIG), go to TRIG.
  - `period_cnt` runs in WAIT and GAP.
- **Selected value** `sel_val` per source:
  - 0: `dist_q`.
  - 1: `enc_in`.
  - 2: `dist_q`-`enc_in`, saturating at 0 when negative (17-bit compare).
- **Auto mode (11):** `rot_idx` cycles 0->1->2->0, advancing when `dwell_cnt` reaches DWELL_MS.
  - Any change of `mode_key` clears `dwell_cnt`.
  - Entering auto starts at `rot_idx`=0.
- **Freeze:** a `hold_key` rising edge toggles `frozen`. While frozen, `number`, `led_bar` and `src_sel` hold their values. The measurement FSM and `dwell_cnt` keep running.
- **Output mapping (when not frozen):**
  - `number` = {12'h000, 2'b00, src, sel_val}.
  - `led_bar` = sel_val==0 ? 8'h00 : (2^(sel_val[15:13]+1))-1, i.e. 1..8 LEDs.
  - `dots` = {frozen, tmo_flag, auto, 5'b0}. `dots` always updates, including while frozen.

## Timing
- Reset values: `meas_start`=0, `number`=0, `dots`=0, `led_bar`=0, `src_sel`=0, `dist_q`=0, `tmo_flag`=0, `frozen`=0, FSM=IDLE. All counters are 0.
- First `meas_start` is asserted 2 cycles after `rst_n` deasserts (IDLE, then TRIG).
- All outputs are registered. There is 1 cycle of latency from `dist_q`/`enc_in`/`mode_key` to `number`/`led_bar`.
- `meas_done` in the same cycle as the timeout: done wins.
- `meas_done` outside WAIT is ignored.
- `rst_n` assertion mid-measurement returns everything to reset values asynchronously. A late `meas_done` after reset is ignored.
- Difference view, `dist_q` equal to `enc_in` -> 0, bar 0.

## Configuration
- `SENSOR_VIEW_AUTO_ROTATE_EN` defined: mode 11 behaves as auto-rotate.
- Not defined: the rotation logic and `dwell_cnt` are removed. Mode 11 displays `sel_val`=0 with src=3, and `dots[5]`=0.

## Structure
- Package `sensor_view_pkg`:
  - enum `meas_state_t` (IDLE/TRIG/WAIT/GAP).
  - enum `view_src_t` (DIST=0, ENC=1, DIFF=2, NONE=3).
  - constant `TIMEOUT_VALUE`=16'hFFFF.
- Sub-module `ms_tick_gen` (prescaler, parameter CLK_HZ, output `ms_tick`), shared with other timed blocks.

## Test plan
All scenarios use CLK_HZ=1000 (one `ms_tick` per cycle), MEAS_PERIOD_MS=60, TIMEOUT_MS=40, DWELL_MS=20.
- **Normal measurement:** release reset, mode 00; respond to each `meas_start` 10 cycles later with `meas_done`, `dist_in`=16'h1234. Expect `number`=32'h0000_1234, `led_bar`=8'h01, and `meas_start` pulses exactly 60 cycles apart.
- **Timeout:** never pulse `meas_done`. Expect `number[15:0]`=16'hFFFF, `dots`=8'h40, `led_bar`=8'hFF, and the next `meas_start` still at 60 cycles.
- **Difference view:** mode 10, `dist_q`=16'h0100, `enc_in`=16'h0040. Expect 16'h00C0 with src digit 2. With `enc_in`=16'h0200, expect 0 and `led_bar`=0.
- **Auto-rotate:** mode 11 with the macro defined. Expect `src_sel` sequence 0,1,2,0 at 20-cycle spacing and `dots[5]`=1. Changing to mode 01 and back restarts at src 0.
- **Freeze:** pulse `hold_key` high, then change `enc_in` in mode 01. Expect `number` unchanged and `dots[7]`=1. A second rising edge resumes tracking within 1 cycle.
- **Reset mid-WAIT:** assert `rst_n`=0 during WAIT, then pulse `meas_done`. Expect all outputs 0. After release, expect a new `meas_start` 2 cycles later.

Source files
------------

// File: rtl/sensor_view_pkg.sv
// Shared types and constants for the sensor view scheduler slice.
package sensor_view_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } meas_state_t;

  typedef enum logic [1:0] {
    DIST = 2'd0,
    ENC  = 2'd1,
    DIFF = 2'd2,
    NONE = 2'd3
  } view_src_t;

  localparam logic [15:0] TIMEOUT_VALUE = 16'hFFFF;

endpackage

// File: rtl/ms_tick_gen.sv
// Prescaler producing a one-cycle ms_tick every CLK_HZ/1000 clocks.
module ms_tick_gen #(
  parameter int CLK_HZ = 27_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic ms_tick
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign ms_tick = (cnt == CW'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (ms_tick) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/sensor_view_scheduler.sv
// Distance measurement sequencer and display view arbiter.
// Optional auto-rotate view for mode 11 is built when SENSOR_VIEW_AUTO_ROTATE_EN is defined.
module sensor_view_scheduler
  import sensor_view_pkg::*;
#(
  parameter int CLK_HZ         = 27_000_000,
  parameter int MEAS_PERIOD_MS = 60,
  parameter int TIMEOUT_MS     = 40,
  parameter int DWELL_MS       = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode_key,
  input  logic        hold_key,
  output logic        meas_start,
  input  logic        meas_done,
  input  logic [15:0] dist_in,
  input  logic [15:0] enc_in,
  output logic [31:0] number,
  output logic [7:0]  dots,
  output logic [7:0]  led_bar,
  output logic [1:0]  src_sel
);

  localparam int CW = 16;
  // Counters hold ticks seen since TRIG, so "reaches N" is the tick that finds N-1.
  localparam logic [CW-1:0] PERIOD_LAST  = CW'(MEAS_PERIOD_MS - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_MS - 1);

  logic ms_tick;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .ms_tick (ms_tick)
  );

  meas_state_t   state, state_nxt;
  logic [CW-1:0] period_cnt, wait_cnt;
  logic [15:0]   dist_q;
  logic          tmo_flag;
  logic          period_hit, wait_hit;

  assign period_hit = ms_tick && (period_cnt == PERIOD_LAST);
  assign wait_hit   = ms_tick && (wait_cnt == TIMEOUT_LAST);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = TRIG;
      TRIG:    state_nxt = WAIT;
      WAIT:    if (meas_done || wait_hit) state_nxt = GAP;
      GAP:     if (period_hit) state_nxt = TRIG;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      meas_start <= 1'b0;
      period_cnt <= '0;
      wait_cnt   <= '0;
      dist_q     <= '0;
      tmo_flag   <= 1'b0;
    end else begin
      state      <= state_nxt;
      meas_start <= (state_nxt == TRIG);
      case (state)
        TRIG: begin
          period_cnt <= {{(CW-1){1'b0}}, ms_tick};
          wait_cnt   <= {{(CW-1){1'b0}}, ms_tick};
        end
        WAIT: begin
          if (ms_tick) begin
            period_cnt <= period_cnt + 1'b1;
            wait_cnt   <= wait_cnt + 1'b1;
          end
          // A done pulse coinciding with the timeout tick takes precedence.
          if (meas_done) begin
            dist_q   <= dist_in;
            tmo_flag <= 1'b0;
          end else if (wait_hit) begin
            dist_q   <= TIMEOUT_VALUE;
            tmo_flag <= 1'b1;
          end
        end
        GAP: if (ms_tick) period_cnt <= period_cnt + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SENSOR_VIEW_AUTO_ROTATE_EN
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_MS - 1);

  logic [1:0]    rot_idx, mode_q;
  logic [CW-1:0] dwell_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 2'b00;
      rot_idx   <= 2'd0;
      dwell_cnt <= '0;
    end else begin
      mode_q <= mode_key;
      // Outside auto the index parks at 0 so entering auto always starts at the distance view.
      if (mode_key != mode_q || mode_key != 2'b11) begin
        dwell_cnt <= '0;
        if (mode_key != 2'b11) rot_idx <= 2'd0;
      end else if (ms_tick) begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_cnt <= '0;
          rot_idx   <= (rot_idx == 2'd2) ? 2'd0 : rot_idx + 1'b1;
        end else begin
          dwell_cnt <= dwell_cnt + 1'b1;
        end
      end
    end
  end
`endif

  view_src_t   src;
  logic        auto_mode;
  logic [16:0] diff;
  logic [15:0] sel_val;
  logic [7:0]  bar_val;

  always_comb begin
    auto_mode = 1'b0;
    src       = view_src_t'(mode_key);
    if (mode_key == 2'b11) begin
`ifdef SENSOR_VIEW_AUTO_ROTATE_EN
      auto_mode = 1'b1;
      src       = view_src_t'(rot_idx);
`else
      src       = NONE;
`endif
    end
    diff = {1'b0, dist_q} - {1'b0, enc_in};
    case (src)
      DIST:    sel_val = dist_q;
      ENC:     sel_val = enc_in;
      DIFF:    sel_val = diff[16] ? 16'h0000 : diff[15:0];
      default: sel_val = 16'h0000;
    endcase
    bar_val = (sel_val == 16'h0000) ? 8'h00 : (8'hFF >> (3'd7 - sel_val[15:13]));
  end

  logic hold_q, frozen, frozen_nxt;

  assign frozen_nxt = frozen ^ (hold_key & ~hold_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= 1'b0;
      frozen  <= 1'b0;
      number  <= '0;
      dots    <= '0;
      led_bar <= '0;
      src_sel <= '0;
    end else begin
      hold_q <= hold_key;
      frozen <= frozen_nxt;
      dots   <= {frozen_nxt, tmo_flag, auto_mode, 5'b00000};
      if (!frozen_nxt) begin
        number  <= {14'h0000, src, sel_val};
        led_bar <= bar_val;
        src_sel <= src;
      end
    end
  end

endmodule

// File: tb/tb_sensor_view_scheduler.sv
// Directed self-checking bench for sensor_view_scheduler (1 ms tick per clock).
module tb_sensor_view_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode_key;
  logic        hold_key;
  logic        meas_start;
  logic        meas_done;
  logic [15:0] dist_in;
  logic [15:0] enc_in;
  logic [31:0] number;
  logic [7:0]  dots;
  logic [7:0]  led_bar;
  logic [1:0]  src_sel;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  sensor_view_scheduler #(
    .CLK_HZ         (1000),
    .MEAS_PERIOD_MS (60),
    .TIMEOUT_MS     (40),
    .DWELL_MS       (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_key   (mode_key),
    .hold_key   (hold_key),
    .meas_start (meas_start),
    .meas_done  (meas_done),
    .dist_in    (dist_in),
    .enc_in     (enc_in),
    .number     (number),
    .dots       (dots),
    .led_bar    (led_bar),
    .src_sel    (src_sel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (meas_start) begin
        at = cyc;
        break;
      end
    end
    check("start_seen", 32'(at >= 0), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_number"}, number, 32'h0);
    check({tag, "_dots"}, {24'h0, dots}, 32'h0);
    check({tag, "_led"}, {24'h0, led_bar}, 32'h0);
    check({tag, "_src"}, {30'h0, src_sel}, 32'h0);
    check({tag, "_start"}, {31'h0, meas_start}, 32'h0);
  endtask

  int s0, s1, s2, s3;

  initial begin
    rst_n = 1'b0; mode_key = 2'b00; hold_key = 1'b0;
    meas_done = 1'b0; dist_in = 16'h0; enc_in = 16'h0;
    step(3);
    check_all_zero("reset");

    // Release: IDLE for one cycle, TRIG in the second.
    rst_n = 1'b1;
    check("start_before_trig", {31'h0, meas_start}, 32'h0);
    step(1);
    check("first_start", {31'h0, meas_start}, 32'h1);
    s0 = cyc;
    step(1);
    check("start_one_cycle", {31'h0, meas_start}, 32'h0);

    // Normal measurement answered 10 cycles after meas_start.
    step(8);
    meas_done = 1'b1; dist_in = 16'h1234;
    step(1);
    meas_done = 1'b0;
    step(1);
    check("normal_number", number, 32'h0000_1234);
    check("normal_led", {24'h0, led_bar}, 32'h01);
    check("normal_src", {30'h0, src_sel}, 32'h0);
    wait_start(s1);
    check("period_60", 32'(s1 - s0), 32'd60);

    // Timeout: no response at all.
    step(40);
    check("pre_timeout_number", number, 32'h0000_1234);
    step(1);
    check("timeout_number", number, 32'h0000_FFFF);
    check("timeout_dots", {24'h0, dots}, 32'h40);
    check("timeout_led", {24'h0, led_bar}, 32'hFF);
    meas_done = 1'b1; dist_in = 16'h0055;
    step(1);
    meas_done = 1'b0;
    step(1);
    check("done_in_gap_ignored", number, 32'h0000_FFFF);
    wait_start(s2);
    check("period_after_timeout", 32'(s2 - s1), 32'd60);

    // Done arriving on the timeout tick wins.
    step(39);
    meas_done = 1'b1; dist_in = 16'h0100;
    step(1);
    meas_done = 1'b0;
    step(1);
    check("done_wins_number", number, 32'h0000_0100);
    check("done_wins_dots", {24'h0, dots}, 32'h00);

    // Difference view with saturation.
    mode_key = 2'b10; enc_in = 16'h0040;
    step(1);
    check("diff_number", number, 32'h0002_00C0);
    check("diff_led", {24'h0, led_bar}, 32'h01);
    check("diff_src", {30'h0, src_sel}, 32'h2);
    enc_in = 16'h0100;
    step(1);
    check("diff_equal", number, 32'h0002_0000);
    check("diff_equal_led", {24'h0, led_bar}, 32'h00);
    enc_in = 16'h0200;
    step(1);
    check("diff_neg_sat", number, 32'h0002_0000);
    check("diff_neg_led", {24'h0, led_bar}, 32'h00);

`ifdef SENSOR_VIEW_AUTO_ROTATE_EN
    mode_key = 2'b11;
    step(1);
    check("auto_src0", {30'h0, src_sel}, 32'h0);
    check("auto_dot", {31'h0, dots[5]}, 32'h1);
    step(20);
    check("auto_src0_hold", {30'h0, src_sel}, 32'h0);
    step(1);
    check("auto_src1", {30'h0, src_sel}, 32'h1);
    step(20);
    check("auto_src2", {30'h0, src_sel}, 32'h2);
    step(20);
    check("auto_src0_wrap", {30'h0, src_sel}, 32'h0);
    mode_key = 2'b01;
    step(3);
    mode_key = 2'b11;
    step(1);
    check("auto_restart", {30'h0, src_sel}, 32'h0);
`else
    mode_key = 2'b11;
    step(1);
    check("mode3_number", number, 32'h0003_0000);
    check("mode3_led", {24'h0, led_bar}, 32'h00);
    check("mode3_src", {30'h0, src_sel}, 32'h3);
    check("mode3_dot", {31'h0, dots[5]}, 32'h0);
`endif

    // Freeze in encoder view.
    mode_key = 2'b01; enc_in = 16'h0333;
    step(1);
    check("enc_number", number, 32'h0001_0333);
    hold_key = 1'b1;
    step(1);
    check("frozen_dot", {31'h0, dots[7]}, 32'h1);
    enc_in = 16'h8000;
    step(2);
    check("frozen_number", number, 32'h0001_0333);
    check("frozen_led", {24'h0, led_bar}, 32'h01);
    hold_key = 1'b0;
    step(1);
    hold_key = 1'b1;
    step(1);
    check("resume_number", number, 32'h0001_8000);
    check("resume_led", {24'h0, led_bar}, 32'h1F);
    check("resume_dot", {31'h0, dots[7]}, 32'h0);
    hold_key = 1'b0;
    step(1);

    // Reset in the middle of WAIT, then a late done pulse.
    wait_start(s3);
    step(5);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    meas_done = 1'b1; dist_in = 16'hABCD;
    step(1);
    meas_done = 1'b0;
    check_all_zero("reset_late_done");
    step(2);
    rst_n = 1'b1; mode_key = 2'b00;
    meas_done = 1'b1; dist_in = 16'hABCD;
    step(1);
    meas_done = 1'b0;
    check("restart_start", {31'h0, meas_start}, 32'h1);
    step(1);
    check("restart_dist_zero", number, 32'h0000_0000);
    check("restart_start_low", {31'h0, meas_start}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
